// File: rtl/prog_loader_pkg.sv
// Shared constants and types for the program loader and the program memory it feeds.
// Base address and depth live here so loader and memory cannot disagree.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [31:0] PROG_BASE_ADDR      = 32'h8000_0000;
  localparam int unsigned PROG_CAPACITY_WORDS = 32768;
  localparam int unsigned LEN_W               = 32;
  localparam int unsigned WORD_IDX_W          = 15;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the loader, bundled together.
// master = host/bench side, slave = loader side.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Four-lane little-endian byte packer: emits a registered word plus a one-cycle
// word_ready pulse on the 4th byte or on a flush, zero-filling unused upper lanes.
module prog_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        flush,
  input  logic [7:0]  data,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] word_q, word_d;
  logic        word_ready_q, word_ready_d;
  logic [31:0] merged;

  always_comb begin
    merged = acc_q;
    case (lane_q)
      2'd0:    merged[7:0]   = data;
      2'd1:    merged[15:8]  = data;
      2'd2:    merged[23:16] = data;
      default: merged[31:24] = data;
    endcase
  end

  // The accumulator is zeroed after every emitted word, which gives zero-fill on flush.
  always_comb begin
    lane_d       = lane_q;
    acc_d        = acc_q;
    word_d       = word_q;
    word_ready_d = 1'b0;
    if (push) begin
      if (lane_q == 2'd3 || flush) begin
        word_d       = merged;
        word_ready_d = 1'b1;
        acc_d        = '0;
        lane_d       = '0;
      end else begin
        acc_d  = merged;
        lane_d = lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q       <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      word_ready_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      word_q       <= word_d;
      word_ready_q <= word_ready_d;
    end
  end

  assign word_ready = word_ready_q;
  assign word       = word_q;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: length header, payload packed into words and written
// to program memory, CPU held in reset until done. PROG_LOADER_CHECKSUM_EN adds a trailing sum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = PROG_BASE_ADDR,
  parameter int unsigned CAPACITY_WORDS = PROG_CAPACITY_WORDS
) (
  input  logic           clk,
  input  logic           rst_n,
  prog_loader_if.slave   bus,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           cpu_rst_n
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(4 * CAPACITY_WORDS);

  state_e                 state_q, state_d;
  logic [1:0]             hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [31:0]            byte_cnt_q, byte_cnt_d;
  logic [WORD_IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [31:0]            waddr_q, waddr_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   cpu_rst_n_q, cpu_rst_n_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]             sum_q, sum_d;
  logic [7:0]             csum_total;
`endif

  logic             xfer;
  logic             push;
  logic             last_byte;
  logic             word_done;
  logic [LEN_W-1:0] len_next;

  assign xfer      = bus.in_valid && in_ready_q;
  assign push      = xfer && (state_q == ST_DATA);
  assign last_byte = (byte_cnt_q == len_q - 32'd1);
  assign word_done = push && ((byte_cnt_q[1:0] == 2'b11) || last_byte);
  assign len_next  = {bus.in_data, len_q[LEN_W-1:8]};
`ifdef PROG_LOADER_CHECKSUM_EN
  assign csum_total = sum_q + bus.in_data;
`endif

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    waddr_d    = waddr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      ST_HDR: begin
        if (xfer) begin
          len_d     = len_next;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            byte_cnt_d = '0;
            if (len_next > MAX_LEN) begin
              state_d = ST_ERR;
            end else if (len_next == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_DONE;
`endif
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (push) begin
          byte_cnt_d = byte_cnt_q + 32'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d      = sum_q + bus.in_data;
`endif
          if (word_done) begin
            waddr_d    = BASE_ADDR + 32'({word_idx_q, 2'b00});
            word_idx_d = word_idx_q + 1'b1;
          end
          if (last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer) begin
          state_d = (csum_total == 8'd0) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: ;
    endcase
  end

  // done lags the DONE state by a cycle so it never coincides with the final write strobe.
  always_comb begin
    in_ready_d  = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
    busy_d      = in_ready_d;
    err_d       = (state_d == ST_ERR);
    done_d      = (state_q == ST_DONE);
    cpu_rst_n_d = done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HDR;
      hdr_cnt_q   <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      waddr_q     <= BASE_ADDR;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      waddr_q     <= waddr_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  prog_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .flush      (last_byte),
    .data       (bus.in_data),
    .word_ready (bus.we),
    .word       (bus.wdata)
  );

  assign bus.in_ready = in_ready_q;
  assign bus.waddr    = waddr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign cpu_rst_n    = cpu_rst_n_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; honours PROG_LOADER_CHECKSUM_EN when defined.
module tb_prog_loader;

  logic clk;
  logic rst_n;
  logic busy, done, err, cpu_rst_n;

  prog_loader_if bus ();

  prog_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_rst_n (cpu_rst_n)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          last_we_cyc;
  int          done_cyc;
  bit          done_seen;
  int          overlap_cnt;
  logic [7:0]  payload[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (bus.we) begin
      wr_addr.push_back(bus.waddr);
      wr_data.push_back(bus.wdata);
      last_we_cyc = cyc;
      if (done) overlap_cnt++;
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one byte after an idle gap and returns at the negedge after its handshake.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL handshake_timeout: observed no in_ready required in_ready=1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [31:0] len, input int maxgap, input logic [7:0] csum_adj);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 4; i++) applyStimulus(len[8*i +: 8], $urandom_range(0, maxgap));
    foreach (payload[i]) begin
      applyStimulus(payload[i], $urandom_range(0, maxgap));
      s = s + payload[i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    applyStimulus(8'h00 - s + csum_adj, $urandom_range(0, maxgap));
`else
    if (csum_adj != 8'h00) $display("[TB] note: checksum adjust %h ignored (sum %h)", csum_adj, s);
`endif
  endtask

  task automatic waitEnd();
    int n;
    n = 0;
    while (!done && !err && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL end_timeout: observed done=%b err=%b required done or err", done, err);
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    done_seen   = 1'b0;
    overlap_cnt = 0;
    last_we_cyc = -1;
    done_cyc    = -1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkTwoWordImage(input string tag);
    checkOutput({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      checkOutput({tag, "_addr0"}, wr_addr[0], 32'h8000_0000);
      checkOutput({tag, "_data0"}, wr_data[0], 32'h0000_0513);
      checkOutput({tag, "_addr1"}, wr_addr[1], 32'h8000_0004);
      checkOutput({tag, "_data1"}, wr_data[1], 32'h0010_0073);
    end
    checkOutput({tag, "_done"},      32'(done),      32'd1);
    checkOutput({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    checkOutput({tag, "_err"},       32'(err),       32'd0);
    checkOutput({tag, "_in_ready"},  32'(bus.in_ready), 32'd0);
    checkOutput({tag, "_busy"},      32'(busy),      32'd0);
    checkOutput({tag, "_overlap"},   32'(overlap_cnt), 32'd0);
`ifndef PROG_LOADER_CHECKSUM_EN
    checkOutput({tag, "_done_lag"},  32'(done_cyc), 32'(last_we_cyc + 1));
`endif
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    done_seen    = 1'b0;
    overlap_cnt  = 0;
    #12;
    $display("[TB] reset state");
    checkOutput("rst_in_ready",  32'(bus.in_ready), 32'd0);
    checkOutput("rst_we",        32'(bus.we),       32'd0);
    checkOutput("rst_waddr",     bus.waddr,         32'h8000_0000);
    checkOutput("rst_wdata",     bus.wdata,         32'h0);
    checkOutput("rst_busy",      32'(busy),         32'd0);
    checkOutput("rst_done",      32'(done),         32'd0);
    checkOutput("rst_err",       32'(err),          32'd0);
    checkOutput("rst_cpu_rst_n", 32'(cpu_rst_n),    32'd0);
    doReset();
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("post_rst_busy",     32'(busy),         32'd1);

    $display("[TB] two-word image back-to-back");
    payload = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
    sendFrame(32'd8, 0, 8'h00);
    waitEnd();
    checkTwoWordImage("b2b");

    $display("[TB] five-byte image with partial last word");
    doReset();
    payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    sendFrame(32'd5, 0, 8'h00);
    waitEnd();
    checkOutput("l5_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      checkOutput("l5_addr0", wr_addr[0], 32'h8000_0000);
      checkOutput("l5_data0", wr_data[0], 32'hDDCC_BBAA);
      checkOutput("l5_addr1", wr_addr[1], 32'h8000_0004);
      checkOutput("l5_data1", wr_data[1], 32'h0000_00EE);
    end
    checkOutput("l5_done", 32'(done), 32'd1);

    $display("[TB] oversize length rejected");
    doReset();
    applyStimulus(8'h04, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    checkOutput("big_err",       32'(err),          32'd1);
    checkOutput("big_in_ready",  32'(bus.in_ready), 32'd0);
    checkOutput("big_cpu_rst_n", 32'(cpu_rst_n),    32'd0);
    checkOutput("big_busy",      32'(busy),         32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("big_nwrites", 32'(wr_addr.size()), 32'd0);
    checkOutput("big_err_hold", 32'(err),  32'd1);
    checkOutput("big_done",     32'(done), 32'd0);

    $display("[TB] maximum legal length accepted");
    doReset();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    checkOutput("max_err",      32'(err),          32'd0);
    checkOutput("max_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("max_busy",     32'(busy),         32'd1);

    $display("[TB] zero-length image");
    doReset();
    payload.delete();
    sendFrame(32'd0, 0, 8'h00);
    waitEnd();
    checkOutput("l0_done",    32'(done), 32'd1);
    checkOutput("l0_err",     32'(err),  32'd0);
    checkOutput("l0_nwrites", 32'(wr_addr.size()), 32'd0);

    $display("[TB] two-word image with random stalls");
    doReset();
    payload = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
    sendFrame(32'd8, 5, 8'h00);
    waitEnd();
    checkTwoWordImage("gap");

    $display("[TB] reset in the middle of a load");
    doReset();
    applyStimulus(8'h08, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("mid_busy",     32'(busy),         32'd0);
    checkOutput("mid_waddr",    bus.waddr,         32'h8000_0000);
    @(negedge clk);
    doReset();
    payload = '{8'h01, 8'h02, 8'h03, 8'h04};
    sendFrame(32'd4, 0, 8'h00);
    waitEnd();
    checkOutput("mid_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      checkOutput("mid_addr0", wr_addr[0], 32'h8000_0000);
      checkOutput("mid_data0", wr_data[0], 32'h0403_0201);
    end
    checkOutput("mid_done", 32'(done), 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    $display("[TB] checksum good");
    doReset();
    payload = '{8'h01, 8'h02, 8'h03, 8'h04};
    sendFrame(32'd4, 0, 8'h00);
    waitEnd();
    checkOutput("cs_ok_done", 32'(done), 32'd1);
    checkOutput("cs_ok_err",  32'(err),  32'd0);

    $display("[TB] checksum bad");
    doReset();
    sendFrame(32'd4, 0, 8'hFF);
    waitEnd();
    checkOutput("cs_bad_err",       32'(err),       32'd1);
    checkOutput("cs_bad_done",      32'(done),      32'd0);
    checkOutput("cs_bad_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("cs_bad_nwrites",   32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      checkOutput("cs_bad_addr0", wr_addr[0], 32'h8000_0000);
      checkOutput("cs_bad_data0", wr_data[0], 32'h0403_0201);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
